// File: rtl/t_ff_updown_counter.sv
// Up/down counter built from a bank of T flip-flops, with hold, parallel
// load, wrap or saturate at the boundaries and a registered terminal-count pulse.
module t_ff_updown_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc
);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] q_bar_q, q_bar_d;
    logic             tc_q, tc_d;

    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;
    logic [WIDTH-1:0] t;
    logic             at_max;
    logic             at_min;
    logic             load;

    // Toggle terms: a bit flips once every lower bit is all-ones (up) or all-zeros (down).
    always_comb begin
        up_t    = '0;
        dn_t    = '0;
        up_t[0] = 1'b1;
        dn_t[0] = 1'b1;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            up_t[i] = up_t[i-1] & q_q[i-1];
            dn_t[i] = dn_t[i-1] & ~q_q[i-1];
        end
        at_max = &q_q;
        at_min = ~|q_q;
    end

    // Mode decode: pick the toggle vector, flag boundary hits, and select load vs toggle.
    always_comb begin
        t    = '0;
        tc_d = 1'b0;
        load = 1'b0;
        if (en) begin
            case (mode)
                MODE_UP: begin
                    tc_d = at_max;
                    if (!(SATURATE && at_max)) t = up_t;
                end
                MODE_DOWN: begin
                    tc_d = at_min;
                    if (!(SATURATE && at_min)) t = dn_t;
                end
                MODE_LOAD: load = 1'b1;
                MODE_HOLD: t = '0;
                default:   t = '0;
            endcase
        end
        q_d     = load ? d : (q_q ^ t);
        q_bar_d = ~q_d;
    end

    // State register; reset clears the count and overrides any mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q     <= '0;
            q_bar_q <= '1;
            tc_q    <= 1'b0;
        end else begin
            q_q     <= q_d;
            q_bar_q <= q_bar_d;
            tc_q    <= tc_d;
        end
    end

    assign q     = q_q;
    assign q_bar = q_bar_q;
    assign tc    = tc_q;

endmodule

// File: tb/tb_t_ff_updown_counter.sv
// Directed bench for t_ff_updown_counter: a wrapping and a saturating
// instance share the same stimulus; expected values are written out per step.
module tb_t_ff_updown_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [3:0] d;
    logic [3:0] q0, qb0, q1, qb1;
    logic       tc0, tc1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    t_ff_updown_counter #(.WIDTH(4), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
        .q(q0), .q_bar(qb0), .tc(tc0)
    );

    t_ff_updown_counter #(.WIDTH(4), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
        .q(q1), .q_bar(qb1), .tc(tc1)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample 1 ns later, and confirm q_bar tracks ~q on both instances.
    task automatic tick();
        logic [3:0] n0, n1;
        @(posedge clk);
        #1;
        n0 = ~q0;
        n1 = ~q1;
        chk("qbar_wrap", qb0, n0);
        chk("qbar_sat", qb1, n1);
    endtask

    task automatic exp_wrap(input string tag, input logic [3:0] eq, input logic etc);
        chk({tag, "_q"}, q0, eq);
        chk({tag, "_tc"}, {3'b000, tc0}, {3'b000, etc});
    endtask

    task automatic exp_sat(input string tag, input logic [3:0] eq, input logic etc);
        chk({tag, "_q"}, q1, eq);
        chk({tag, "_tc"}, {3'b000, tc1}, {3'b000, etc});
    endtask

    initial begin
        // Reset held for two edges with up mode requested
        rst = 1'b1; en = 1'b1; mode = 2'b01; d = 4'h0;
        tick(); tick();
        exp_wrap("rst_wrap", 4'h0, 1'b0);
        exp_sat("rst_sat", 4'h0, 1'b0);
        chk("rst_qbar", qb0, 4'hF);

        // Up wrap
        rst = 1'b0; mode = 2'b11; d = 4'hE;
        tick(); exp_wrap("ld_E", 4'hE, 1'b0);
        mode = 2'b01;
        tick(); exp_wrap("up_F", 4'hF, 1'b0);
        tick(); exp_wrap("up_wrap0", 4'h0, 1'b1);
        tick(); exp_wrap("up_1", 4'h1, 1'b0);

        // Down wrap
        mode = 2'b11; d = 4'h1;
        tick(); exp_wrap("ld_1", 4'h1, 1'b0);
        mode = 2'b10;
        tick(); exp_wrap("dn_0", 4'h0, 1'b0);
        tick(); exp_wrap("dn_wrapF", 4'hF, 1'b1);
        tick(); exp_wrap("dn_E", 4'hE, 1'b0);

        // Saturate at all-ones, then release by counting down
        mode = 2'b11; d = 4'hF;
        tick(); exp_sat("sat_ldF", 4'hF, 1'b0); exp_wrap("ld_F", 4'hF, 1'b0);
        mode = 2'b01;
        tick(); exp_sat("sat_up1", 4'hF, 1'b1); exp_wrap("wrap_up1", 4'h0, 1'b1);
        tick(); exp_sat("sat_up2", 4'hF, 1'b1); exp_wrap("wrap_up2", 4'h1, 1'b0);
        mode = 2'b10;
        tick(); exp_sat("sat_dnE", 4'hE, 1'b0); exp_wrap("wrap_dn0", 4'h0, 1'b0);

        // Saturate at zero on down
        mode = 2'b11; d = 4'h0;
        tick(); exp_sat("sat_ld0", 4'h0, 1'b0);
        mode = 2'b10;
        tick(); exp_sat("sat_dn0a", 4'h0, 1'b1); exp_wrap("wrap_dnF", 4'hF, 1'b1);
        tick(); exp_sat("sat_dn0b", 4'h0, 1'b1);

        // Hold and enable at count 5
        mode = 2'b11; d = 4'h4;
        tick(); exp_wrap("ld_4", 4'h4, 1'b0);
        mode = 2'b01;
        tick(); exp_wrap("up_5", 4'h5, 1'b0);
        en = 1'b0;
        tick(); exp_wrap("en0_a", 4'h5, 1'b0);
        tick(); exp_wrap("en0_b", 4'h5, 1'b0);
        tick(); exp_wrap("en0_c", 4'h5, 1'b0);
        en = 1'b1; mode = 2'b00;
        tick(); exp_wrap("hold_a", 4'h5, 1'b0);
        tick(); exp_wrap("hold_b", 4'h5, 1'b0);

        // en=0 at the boundary suppresses both wrap and tc
        mode = 2'b11; d = 4'hF;
        tick(); exp_wrap("ld_F2", 4'hF, 1'b0);
        en = 1'b0; mode = 2'b01;
        tick(); exp_wrap("en0_atF", 4'hF, 1'b0); exp_sat("sat_en0_atF", 4'hF, 1'b0);
        en = 1'b1;

        // Reset mid-count beats a simultaneous load
        mode = 2'b11; d = 4'h8;
        tick(); exp_wrap("ld_8", 4'h8, 1'b0);
        mode = 2'b01;
        tick(); exp_wrap("up_9", 4'h9, 1'b0);
        rst = 1'b1; mode = 2'b11; d = 4'hA;
        tick(); exp_wrap("rst_mid", 4'h0, 1'b0); exp_sat("sat_rst_mid", 4'h0, 1'b0);
        rst = 1'b0; mode = 2'b01;
        tick(); exp_wrap("resume_1", 4'h1, 1'b0);
        tick(); exp_wrap("resume_2", 4'h2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
